// File: rtl/apb_2_lint_if.sv
// APB-slave plus LINT-master signal bundle for the apb_2_lint bridge.
// The slave modport is the bridge's view; master is the environment's view
// (APB master driving the bus and LINT memory answering requests).
interface apb_2_lint_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 10,
  parameter int unsigned AUX_WIDTH  = 8
);
  // APB side
  logic [ADDR_WIDTH-1:0] slave_PADDR;
  logic [DATA_WIDTH-1:0] slave_PWDATA;
  logic                  slave_PWRITE;
  logic [BE_WIDTH-1:0]   slave_PSTRB;
  logic                  slave_PSEL;
  logic                  slave_PENABLE;
  logic [DATA_WIDTH-1:0] slave_PRDATA;
  logic                  slave_PREADY;
  logic                  slave_PSLVERR;
  // LINT side
  logic                  data_req_o;
  logic [ADDR_WIDTH-1:0] data_add_o;
  logic                  data_wen_o;
  logic [DATA_WIDTH-1:0] data_wdata_o;
  logic [BE_WIDTH-1:0]   data_be_o;
  logic [AUX_WIDTH-1:0]  data_aux_o;
  logic [ID_WIDTH-1:0]   data_ID_o;
  logic                  data_gnt_i;
  logic                  data_r_valid_i;
  logic [DATA_WIDTH-1:0] data_r_rdata_i;
  logic                  data_r_opc_i;

  modport slave (
    input  slave_PADDR, slave_PWDATA, slave_PWRITE, slave_PSTRB,
           slave_PSEL, slave_PENABLE,
    output slave_PRDATA, slave_PREADY, slave_PSLVERR,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
           data_aux_o, data_ID_o,
    input  data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i
  );

  modport master (
    output slave_PADDR, slave_PWDATA, slave_PWRITE, slave_PSTRB,
           slave_PSEL, slave_PENABLE,
    input  slave_PRDATA, slave_PREADY, slave_PSLVERR,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
           data_aux_o, data_ID_o,
    output data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i
  );
endinterface

// File: rtl/apb_2_lint.sv
// APB slave to LINT/TCDM master bridge. One outstanding single-word access;
// the APB access phase is stretched (PREADY low) until the LINT response
// returns. Request fields are registered in the setup phase, so there is no
// combinational path from the APB inputs to the LINT outputs.
module apb_2_lint #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 10,
  parameter int unsigned AUX_WIDTH  = 8,
  parameter int unsigned ID_VALUE   = 0,
  parameter int unsigned AUX_VALUE  = 0
) (
  input logic          clk,
  input logic          rst_n,
  apb_2_lint_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] add_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wen_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pslverr_q;

  // Transaction sequencer: capture request in setup, hold req until grant,
  // capture response, then complete the APB access for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      add_q     <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b1;
      be_q      <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.slave_PSEL) begin
            add_q   <= bus.slave_PADDR;
            wdata_q <= bus.slave_PWDATA;
            wen_q   <= ~bus.slave_PWRITE;
            be_q    <= bus.slave_PWRITE ? bus.slave_PSTRB : '1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.data_gnt_i) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (bus.data_r_valid_i) begin
            prdata_q  <= bus.data_r_rdata_i;
            pslverr_q <= bus.data_r_opc_i;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes are decoded from the registered state, so they cannot glitch.
  assign bus.data_req_o    = (state == REQ);
  assign bus.slave_PREADY  = (state == RESP);
  assign bus.slave_PRDATA  = prdata_q;
  assign bus.slave_PSLVERR = pslverr_q;

  assign bus.data_add_o    = add_q;
  assign bus.data_wdata_o  = wdata_q;
  assign bus.data_wen_o    = wen_q;
  assign bus.data_be_o     = be_q;
  assign bus.data_ID_o     = ID_WIDTH'(ID_VALUE);
  assign bus.data_aux_o    = AUX_WIDTH'(AUX_VALUE);

endmodule

// File: tb/tb_apb_2_lint.sv
// Self-checking bench for apb_2_lint: the bench acts as APB master and as
// LINT memory. Expected responses go into a scoreboard queue when a transfer
// is issued and are popped when PREADY completes it.
module tb_apb_2_lint;

  localparam logic [9:0] ID_V  = 10'h2A5;
  localparam logic [7:0] AUX_V = 8'hC3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  apb_2_lint_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
    .ID_WIDTH(10), .AUX_WIDTH(8)
  ) bus ();

  apb_2_lint #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
    .ID_WIDTH(10), .AUX_WIDTH(8),
    .ID_VALUE(32'h2A5), .AUX_VALUE(32'hC3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Issue one APB transfer starting in the current (IDLE) cycle and play the
  // LINT memory. Ends one cycle after RESP with PSEL dropped.
  task automatic transfer(input logic [31:0] addr, input logic [31:0] wd,
                          input logic wr, input logic [3:0] strb,
                          input int gdly, input logic [31:0] rdata,
                          input logic opc, input bit stray,
                          output int req_cyc);
    exp_t e;
    logic [3:0] ebe;
    int n;
    ebe = wr ? strb : 4'hF;
    bus.slave_PSEL    = 1'b1;
    bus.slave_PENABLE = 1'b0;
    bus.slave_PADDR   = addr;
    bus.slave_PWDATA  = wd;
    bus.slave_PWRITE  = wr;
    bus.slave_PSTRB   = strb;
    e.is_read = !wr;
    e.data    = rdata;
    e.err     = opc;
    sb.push_back(e);
    if (stray) begin
      bus.data_r_valid_i = 1'b1;
      bus.data_r_rdata_i = 32'hBAD0_BAD0;
      bus.data_r_opc_i   = 1'b1;
    end
    @(negedge clk);
    bus.data_r_valid_i = 1'b0;
    bus.data_r_opc_i   = 1'b0;
    bus.slave_PENABLE  = 1'b1;
    n = 0;
    while (bus.data_req_o !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL req_latency: extra cycles=%0d required=0", n);
    end
    req_cyc = cyc;
    for (int i = 0; i <= gdly; i++) begin
      checks++;
      if (bus.data_req_o !== 1'b1 || bus.data_add_o !== addr ||
          bus.data_wen_o !== ~wr || bus.data_be_o !== ebe ||
          bus.data_wdata_o !== wd || bus.slave_PREADY !== 1'b0) begin
        failures++;
        $display("FAIL req_fields[%0d]: req=%b add=%h wen=%b be=%b wdata=%h pready=%b required req=1 add=%h wen=%b be=%b wdata=%h pready=0",
                 i, bus.data_req_o, bus.data_add_o, bus.data_wen_o, bus.data_be_o,
                 bus.data_wdata_o, bus.slave_PREADY, addr, ~wr, ebe, wd);
      end
      bus.data_gnt_i = (i == gdly);
      @(negedge clk);
    end
    bus.data_gnt_i = 1'b0;
    checks++;
    if (bus.data_req_o !== 1'b0 || bus.slave_PREADY !== 1'b0) begin
      failures++;
      $display("FAIL wait_rsp: req=%b pready=%b required 0 0",
               bus.data_req_o, bus.slave_PREADY);
    end
    bus.data_r_valid_i = 1'b1;
    bus.data_r_rdata_i = rdata;
    bus.data_r_opc_i   = opc;
    @(negedge clk);
    bus.data_r_valid_i = 1'b0;
    bus.data_r_rdata_i = '0;
    bus.data_r_opc_i   = 1'b0;
    n = 0;
    while (bus.slave_PREADY !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL pready_latency: extra cycles=%0d required=0", n);
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: queue empty at response, required 1 entry");
    end else begin
      e = sb.pop_front();
      if (e.is_read) begin
        checks++;
        if (bus.slave_PRDATA !== e.data) begin
          failures++;
          $display("FAIL prdata: got %h required %h", bus.slave_PRDATA, e.data);
        end
      end
      checks++;
      if (bus.slave_PSLVERR !== e.err) begin
        failures++;
        $display("FAIL pslverr: got %b required %b", bus.slave_PSLVERR, e.err);
      end
    end
    @(negedge clk);
    bus.slave_PSEL    = 1'b0;
    bus.slave_PENABLE = 1'b0;
    checks++;
    if (bus.slave_PREADY !== 1'b0 || bus.data_req_o !== 1'b0) begin
      failures++;
      $display("FAIL after_resp: pready=%b req=%b required 0 0",
               bus.slave_PREADY, bus.data_req_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.slave_PSEL = 1'b0; bus.slave_PENABLE = 1'b0;
    bus.slave_PADDR = '0; bus.slave_PWDATA = '0;
    bus.slave_PWRITE = 1'b0; bus.slave_PSTRB = '0;
    bus.data_gnt_i = 1'b0; bus.data_r_valid_i = 1'b0;
    bus.data_r_rdata_i = '0; bus.data_r_opc_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.data_req_o !== 1'b0 || bus.slave_PREADY !== 1'b0 ||
        bus.slave_PSLVERR !== 1'b0 || bus.slave_PRDATA !== 32'h0 ||
        bus.data_add_o !== 32'h0 || bus.data_wdata_o !== 32'h0 ||
        bus.data_wen_o !== 1'b1 || bus.data_be_o !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: req=%b pready=%b pslverr=%b prdata=%h add=%h wdata=%h wen=%b be=%b required 0 0 0 0 0 0 1 0",
               bus.data_req_o, bus.slave_PREADY, bus.slave_PSLVERR, bus.slave_PRDATA,
               bus.data_add_o, bus.data_wdata_o, bus.data_wen_o, bus.data_be_o);
    end
    checks++;
    if (bus.data_ID_o !== ID_V || bus.data_aux_o !== AUX_V) begin
      failures++;
      $display("FAIL id_aux: id=%h aux=%h required %h %h",
               bus.data_ID_o, bus.data_aux_o, ID_V, AUX_V);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int rc;
    transfer(32'h1C00_0010, 32'hA5A5_0001, 1'b1, 4'b0011, 0, 32'h0, 1'b0, 1'b0, rc);
  endtask

  task automatic test_read();
    int rc;
    transfer(32'h1C00_0020, 32'h0, 1'b0, 4'b0000, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, rc);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.slave_PRDATA !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL prdata_hold: got %h required deadbeef", bus.slave_PRDATA);
    end
  endtask

  task automatic test_grant_stall();
    int rc;
    transfer(32'h1C00_0104, 32'h0BAD_F00D, 1'b1, 4'b1100, 5, 32'h0, 1'b0, 1'b0, rc);
    transfer(32'h1C00_0108, 32'h0, 1'b0, 4'b0000, 5, 32'h5566_7788, 1'b0, 1'b0, rc);
  endtask

  task automatic test_error();
    int rc;
    transfer(32'h1C00_0200, 32'h0, 1'b0, 4'b0000, 0, 32'h1234_5678, 1'b1, 1'b0, rc);
    checks++;
    if (bus.slave_PSLVERR !== 1'b1) begin
      failures++;
      $display("FAIL pslverr_hold: got %b required 1", bus.slave_PSLVERR);
    end
    transfer(32'h1C00_0204, 32'hCAFE_0002, 1'b1, 4'b1111, 1, 32'h0, 1'b0, 1'b0, rc);
  endtask

  task automatic test_back_to_back();
    int rc1;
    int rc2;
    transfer(32'h1C00_0300, 32'h1111_2222, 1'b1, 4'b0101, 0, 32'h0, 1'b0, 1'b0, rc1);
    transfer(32'h1C00_0304, 32'h0, 1'b0, 4'b0000, 0, 32'h8765_4321, 1'b0, 1'b1, rc2);
    checks++;
    if (rc2 - rc1 != 4) begin
      failures++;
      $display("FAIL b2b_spacing: req-to-req cycles=%0d required 4", rc2 - rc1);
    end
    // Stray response while idle and unselected must not complete anything.
    bus.data_r_valid_i = 1'b1;
    bus.data_r_rdata_i = 32'hFFFF_0000;
    bus.data_r_opc_i   = 1'b1;
    @(negedge clk);
    bus.data_r_valid_i = 1'b0;
    bus.data_r_opc_i   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.slave_PREADY !== 1'b0 || bus.data_req_o !== 1'b0 ||
          bus.slave_PRDATA !== 32'h8765_4321 || bus.slave_PSLVERR !== 1'b0) begin
        failures++;
        $display("FAIL stray_rvalid[%0d]: pready=%b req=%b prdata=%h pslverr=%b required 0 0 87654321 0",
                 i, bus.slave_PREADY, bus.data_req_o, bus.slave_PRDATA, bus.slave_PSLVERR);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bus.slave_PSEL = 1'b1; bus.slave_PENABLE = 1'b0;
    bus.slave_PADDR = 32'h1C00_0400; bus.slave_PWRITE = 1'b0;
    bus.slave_PSTRB = 4'h0; bus.slave_PWDATA = '0;
    @(negedge clk);
    bus.slave_PENABLE = 1'b1;
    bus.data_gnt_i = 1'b1;
    @(negedge clk);
    bus.data_gnt_i = 1'b0;
    checks++;
    if (bus.data_req_o !== 1'b0 || bus.slave_PRDATA === 32'h0) begin
      failures++;
      $display("FAIL pre_reset_wait: req=%b prdata=%h required req=0 prdata nonzero",
               bus.data_req_o, bus.slave_PRDATA);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.data_req_o !== 1'b0 || bus.slave_PREADY !== 1'b0 ||
        bus.slave_PRDATA !== 32'h0 || bus.slave_PSLVERR !== 1'b0 ||
        bus.data_wen_o !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: req=%b pready=%b prdata=%h pslverr=%b wen=%b required 0 0 0 0 1",
               bus.data_req_o, bus.slave_PREADY, bus.slave_PRDATA,
               bus.slave_PSLVERR, bus.data_wen_o);
    end
    bus.slave_PSEL = 1'b0; bus.slave_PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.data_r_valid_i = 1'b1;
    bus.data_r_rdata_i = 32'h7777_7777;
    bus.data_r_opc_i   = 1'b1;
    @(negedge clk);
    bus.data_r_valid_i = 1'b0;
    bus.data_r_opc_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.slave_PREADY !== 1'b0 || bus.slave_PRDATA !== 32'h0 ||
          bus.slave_PSLVERR !== 1'b0) begin
        failures++;
        $display("FAIL late_rvalid[%0d]: pready=%b prdata=%h pslverr=%b required 0 0 0",
                 i, bus.slave_PREADY, bus.slave_PRDATA, bus.slave_PSLVERR);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write();
    test_read();
    test_grant_stall();
    test_error();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
